// File: rtl/dm_stage_pipe_if.sv
// Handshake and data bundle between the execute stage, the data-memory stage
// and writeback. The master side drives operations; the slave side is the stage itself.
interface dm_stage_pipe_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int OPC_W  = 4,
    parameter int REG_W  = 3,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] address_input;
    logic [DATA_W-1:0] alu_input;
    logic [DATA_W-1:0] pipe_stg_input;
    logic [REG_W-1:0]  rd_in;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] mux21_output;
    logic [REG_W-1:0]  wb_rd;
    logic              wb_is_load;
    logic              mem_fault;
    logic [CNT_W-1:0]  load_count;
    logic [CNT_W-1:0]  store_count;

    modport master (
        output in_valid, opcode, address_input, alu_input, pipe_stg_input, rd_in,
               flush, out_ready,
        input  in_ready, out_valid, mux21_output, wb_rd, wb_is_load, mem_fault,
               load_count, store_count
    );

    modport slave (
        input  in_valid, opcode, address_input, alu_input, pipe_stg_input, rd_in,
               flush, out_ready,
        output in_ready, out_valid, mux21_output, wb_rd, wb_is_load, mem_fault,
               load_count, store_count
    );
endinterface

// File: rtl/dm_stage_pipe.sv
// Data-memory pipeline stage: executes loads/stores against a local memory and
// registers the writeback value behind a valid/ready output register.
module dm_stage_pipe #(
    parameter int               DATA_W   = 8,
    parameter int               ADDR_W   = 8,
    parameter int               DEPTH    = 256,
    parameter int               OPC_W    = 4,
    parameter logic [OPC_W-1:0] OP_LOAD  = 4'b1101,
    parameter logic [OPC_W-1:0] OP_STORE = 4'b1110,
    parameter int               REG_W    = 3,
    parameter int               CNT_W    = 16
) (
    input logic            clk,
    input logic            rst_n,
    dm_stage_pipe_if.slave bus
);
    localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              in_range;
    logic              is_load;
    logic              is_store;
    logic              do_write;
    logic              do_load;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_data;

    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
    assign is_load      = (bus.opcode == OP_LOAD);
    assign is_store     = (bus.opcode == OP_STORE);
    assign in_range     = (32'(bus.address_input) < 32'(DEPTH));
    assign idx          = bus.address_input[IDX_W-1:0];
    // Out-of-range reads never touch the array; they resolve to zero.
    assign rd_data      = in_range ? mem[idx] : '0;
    assign do_write     = accept & is_store & in_range;
    assign do_load      = accept & is_load & in_range;

    // Memory is deliberately left out of reset so contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (do_write) mem[idx] <= bus.alu_input;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.mux21_output <= '0;
            bus.wb_rd        <= '0;
            bus.wb_is_load   <= 1'b0;
            bus.mem_fault    <= 1'b0;
            bus.load_count   <= '0;
            bus.store_count  <= '0;
        end else begin
            if (bus.flush) begin
                bus.out_valid <= 1'b0;
            end else if (accept) begin
                bus.out_valid    <= 1'b1;
                bus.wb_rd        <= bus.rd_in;
                bus.wb_is_load   <= is_load;
                bus.mem_fault    <= (is_load | is_store) & ~in_range;
                bus.mux21_output <= is_load ? rd_data : bus.pipe_stg_input;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            if (do_load && bus.load_count != CNT_MAX)
                bus.load_count <= bus.load_count + 1'b1;
            if (do_write && bus.store_count != CNT_MAX)
                bus.store_count <= bus.store_count + 1'b1;
        end
    end
endmodule
